mac_tx_arbiter: RTL and testbench
=================================

// Module: mac_tx_arbiter
// PURPOSE
// - Frame-level arbiter between NUM_SRC AXI-Stream byte sources (e.g. ARP, ICMP, UDP) and the single MAC TX stream feeding mac_tx_crc_calculate.
// - Grants one source per frame and holds the grant until that source's tlast handshake, so frames are never interleaved.
// - Default fairness is round robin.
// PARAMETERS
// - NUM_SRC    3     number of requesting sources, 2..8
// - DATA_W     8     stream data width, bits
// - SRC_W      $clog2(NUM_SRC)  grant index width (localparam, derived)
// PORTS
// - logic_clk      in   1              single clock; all ports are synchronous to it
// - logic_rst_n    in   1              asynchronous, active-low reset
// - s_tdata        in   NUM_SRC*DATA_W source i occupies bits [DATA_W*i +: DATA_W]
// - s_tvalid       in   NUM_SRC        per-source valid; a source requests when tvalid=1
// - s_tready       out  NUM_SRC        per-source ready
// - s_tlast        in   NUM_SRC        per-source end of frame
// - mac_tdata_out  out  DATA_W         to mac_tdata_in
// - mac_tvalid_out out  1
// - mac_tready_in  in   1              from mac_tready_out; registered downstream, may lag tvalid
// - mac_tlast_out  out  1
// - grant_id       out  SRC_W          index of the granted source; valid while busy=1
// - busy           out  1              a frame is in progress
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, rr_ptr=0, grant_id=0, busy=0, s_tready=0, mac_tvalid_out=0, mac_tlast_out=0, mac_tdata_out=0.
// - FSM states: IDLE, XFER, GAP.
// - IDLE: if any s_tvalid=1, register grant = first requesting index at or after rr_ptr (wrapping modulo NUM_SRC); go to XFER.
//   - Grant latency: 1 cycle from request to XFER.
// - XFER: mux is combinational from the registered grant g:
//   - mac_tdata_out=s_tdata[g], mac_tvalid_out=s_tvalid[g], mac_tlast_out=s_tlast[g]
//   - s_tready[g]=mac_tready_in; s_tready of every other source = 0.
//   - Byte transfer = mac_tvalid_out & mac_tready_in.
//   - A transfer with mac_tlast_out=1 ends the frame: rr_ptr <= (g+1) mod NUM_SRC, then go to GAP.
// - GAP: one bubble cycle. All outputs are 0 and no grant is made. The downstream FSM returns to IDLE during this cycle. Next state is IDLE.
// - busy=1 in XFER and GAP. grant_id holds its value until the next grant.
// - Sources whose tvalid drops mid-frame are not preempted. The grant holds indefinitely until tlast; the watchdog belongs downstream.
// - A non-granted source's tvalid/tdata/tlast are ignored. Rising requests during XFER/GAP wait for IDLE.
// - Simultaneous requests in IDLE: round robin (or priority, see CONFIGURATION) decides. The losers keep tvalid asserted and are served later.
// - rr_ptr wraps NUM_SRC-1 -> 0. Indices >= NUM_SRC are never granted.
// - Reset asserted mid-frame: immediate return to IDLE with all outputs 0. The truncated frame is the responsibility of the downstream reset.
// - Single-byte frame (tlast on first byte) is legal: XFER lasts until that one handshake.
// CONFIGURATION
// - Macro MAC_TX_ARB_STRICT_PRIO_EN.
// - Defined: IDLE grants the lowest-index requesting source (source 0 = highest priority). rr_ptr is not used and stays 0.
// - Undefined (default): round robin exactly as described above.
// - Handshake and FSM behaviour are identical in both modes.
// STRUCTURE
// - mac_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_GAP} arb_state_t; localparam MAC_DATA_W = 8.
// - Sub-module mac_rr_pick (combinational): inputs req[NUM_SRC] and ptr; outputs found and idx.
//   - Under MAC_TX_ARB_STRICT_PRIO_EN, ptr is tied to 0.
// - Top level holds the FSM, grant/rr_ptr registers and the output mux.
// TESTING
// - Single source, NUM_SRC=3:
//   - src1 sends a 5-byte frame 0x11..0x15 with ready always 1 -> grant_id=1, 5 bytes out in order, tlast on 0x15, then 1 GAP cycle with tvalid=0.
// - All 3 sources request continuously with 2-byte frames:
//   - round robin -> grant order 0,1,2,0.
//   - strict prio -> 0,0,0 while src0 keeps requesting.
// - Backpressure: mac_tready_in toggles 1/0 each cycle during a 4-byte frame -> no byte lost or duplicated; s_tready of non-granted sources stays 0 throughout.
// - Source stall: src2 drops tvalid for 10 cycles mid-frame while src0 requests -> grant stays 2, src0 is served only after src2's tlast plus GAP.
// - Reset mid-frame: logic_rst_n low during byte 3 of an 8-byte frame -> all outputs 0 in the same cycle, busy=0, rr_ptr=0; after release, the first request is granted normally.
// - Single-byte frames from src0 and src1 back to back -> each is XFER 1 cycle + GAP 1 cycle; grants 0 then 1.

Source files
------------

// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared types and constants for the MAC transmit path.
//   arb_state_t : frame arbiter FSM states (IDLE -> XFER -> GAP -> IDLE)
//   MAC_DATA_W  : byte-stream width of the MAC TX interface
//   wrap_inc    : index increment that wraps to 0 at n
// ---------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_XFER,
        ARB_GAP
    } arb_state_t;

    localparam int MAC_DATA_W = 8;

    function automatic int wrap_inc(input int idx, input int n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/mac_rr_pick.sv
// ---------------------------------------------------------------------------
// mac_rr_pick
// Combinational round-robin selector: returns the first asserted request at
// or after ptr, wrapping modulo NUM_SRC. With ptr tied to 0 it degenerates
// to a fixed lowest-index-wins priority encoder.
// Ports:
//   req   in  NUM_SRC  request vector
//   ptr   in  SRC_W    starting index for the search (must be < NUM_SRC)
//   found out 1        at least one request is asserted
//   idx   out SRC_W    index of the selected request (0 when found=0)
// ---------------------------------------------------------------------------
module mac_rr_pick #(
    parameter int NUM_SRC = 3,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic               found,
    output logic [SRC_W-1:0]   idx
);

    int cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = SRC_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mac_tx_arbiter.sv
// ---------------------------------------------------------------------------
// mac_tx_arbiter
// Frame-level arbiter between NUM_SRC AXI-Stream byte sources and the single
// MAC TX stream. One source is granted per frame and the grant is held until
// that source's tlast handshake, so frames never interleave. Every frame is
// followed by one idle GAP cycle in which the downstream FSM rearms.
//
// Build option:
//   MAC_TX_ARB_STRICT_PRIO_EN  defined   -> lowest requesting index wins
//                              undefined -> round robin (default)
//
// Ports:
//   logic_clk      in   1               clock
//   logic_rst_n    in   1               asynchronous active-low reset
//   s_tdata        in   NUM_SRC*DATA_W  source i at [DATA_W*i +: DATA_W]
//   s_tvalid       in   NUM_SRC         per-source valid (also the request)
//   s_tready       out  NUM_SRC         per-source ready (granted source only)
//   s_tlast        in   NUM_SRC         per-source end of frame
//   mac_tdata_out  out  DATA_W          muxed byte to the MAC
//   mac_tvalid_out out  1               muxed valid
//   mac_tready_in  in   1               MAC ready
//   mac_tlast_out  out  1               muxed end of frame
//   grant_id       out  SRC_W           granted source, meaningful while busy
//   busy           out  1               frame in progress (XFER or GAP)
// ---------------------------------------------------------------------------
module mac_tx_arbiter
    import mac_pkg::*;
#(
    parameter  int NUM_SRC = 3,
    parameter  int DATA_W  = MAC_DATA_W,
    localparam int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                      logic_clk,
    input  logic                      logic_rst_n,
    input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]        s_tvalid,
    output logic [NUM_SRC-1:0]        s_tready,
    input  logic [NUM_SRC-1:0]        s_tlast,
    output logic [DATA_W-1:0]         mac_tdata_out,
    output logic                      mac_tvalid_out,
    input  logic                      mac_tready_in,
    output logic                      mac_tlast_out,
    output logic [SRC_W-1:0]          grant_id,
    output logic                      busy
);

    arb_state_t         state_q, state_d;
    logic [SRC_W-1:0]   grant_q, grant_d;
    logic [SRC_W-1:0]   pick_ptr;
    logic               pick_found;
    logic [SRC_W-1:0]   pick_idx;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_valid;
    logic               sel_last;
    logic               xfer_end;

    // Granted source's stream, selected from the registered grant only.
    assign sel_data  = s_tdata[DATA_W*grant_q +: DATA_W];
    assign sel_valid = s_tvalid[grant_q];
    assign sel_last  = s_tlast[grant_q];

    // Final handshake of the current frame.
    assign xfer_end  = (state_q == ARB_XFER) && sel_valid && mac_tready_in && sel_last;

`ifdef MAC_TX_ARB_STRICT_PRIO_EN
    // Fixed priority: the search always starts at source 0.
    assign pick_ptr = '0;
`else
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    // The source just served becomes the lowest priority for the next frame.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer_end) begin
            rr_ptr_d = SRC_W'(wrap_inc(int'(grant_q), NUM_SRC));
        end
    end

    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign pick_ptr = rr_ptr_q;
`endif

    mac_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_pick (
        .req   (s_tvalid),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        s_tready       = '0;
        mac_tdata_out  = '0;
        mac_tvalid_out = 1'b0;
        mac_tlast_out  = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ARB_XFER;
                end
            end
            ARB_XFER: begin
                // No preemption: a stalled granted source keeps the grant.
                mac_tdata_out     = sel_data;
                mac_tvalid_out    = sel_valid;
                mac_tlast_out     = sel_last;
                s_tready[grant_q] = mac_tready_in;
                if (xfer_end) begin
                    state_d = ARB_GAP;
                end
            end
            ARB_GAP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mac_tx_arbiter.sv
module tb_mac_tx_arbiter;

    localparam int NS = 3;
    localparam int DW = 8;

    logic              logic_clk;
    logic              logic_rst_n;
    logic [NS*DW-1:0]  s_tdata;
    logic [NS-1:0]     s_tvalid;
    logic [NS-1:0]     s_tready;
    logic [NS-1:0]     s_tlast;
    logic [DW-1:0]     mac_tdata_out;
    logic              mac_tvalid_out;
    logic              mac_tready_in;
    logic              mac_tlast_out;
    logic [1:0]        grant_id;
    logic              busy;

    mac_tx_arbiter #(.NUM_SRC(NS), .DATA_W(DW)) dut (
        .logic_clk      (logic_clk),
        .logic_rst_n    (logic_rst_n),
        .s_tdata        (s_tdata),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .s_tlast        (s_tlast),
        .mac_tdata_out  (mac_tdata_out),
        .mac_tvalid_out (mac_tvalid_out),
        .mac_tready_in  (mac_tready_in),
        .mac_tlast_out  (mac_tlast_out),
        .grant_id       (grant_id),
        .busy           (busy)
    );

    initial begin
        logic_clk = 1'b0;
        forever #5 logic_clk = ~logic_clk;
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Source stimulus queues: [9]=stall cycle, [8]=tlast, [7:0]=data.
    logic [9:0]  srcq [NS][$];
    // Scoreboard: {grant, tlast, data} in expected MAC order.
    logic [10:0] exp_q [$];
    int          xcyc_q [$];
    logic [NS-1:0] hs;
    logic [NS-1:0] stall_drv;
    logic          rdy_mode;
    logic          gap_pend;
    int            cyc;

    task automatic push_frame(input int s, input logic [7:0] base, input int len,
                              input int stall_at, input int stall_len);
        for (int b = 0; b < len; b++) begin
            if (b == stall_at) begin
                for (int j = 0; j < stall_len; j++) srcq[s].push_back(10'h200);
            end
            srcq[s].push_back({1'b0, (b == len - 1), 8'(base + b)});
        end
    endtask

    task automatic expect_frame(input int s, input logic [7:0] base, input int len, input int n);
        for (int b = 0; b < n; b++) begin
            exp_q.push_back({2'(s), (b == len - 1), 8'(base + b)});
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge logic_clk);
            #3;
            if (srcq[0].size() == 0 && srcq[1].size() == 0 && srcq[2].size() == 0 &&
                exp_q.size() == 0 && !busy) return;
        end
        check("drain_timeout", 1, 0);
    endtask

    // Cycle engine: drives sources at negedge, samples/scores 1 time unit before posedge.
    initial begin
        s_tdata = '0; s_tvalid = '0; s_tlast = '0; mac_tready_in = 1'b1;
        hs = '0; stall_drv = '0; rdy_mode = 1'b0; gap_pend = 1'b0; cyc = 0;
        forever begin
            @(negedge logic_clk);
            cyc++;
            for (int i = 0; i < NS; i++) begin
                if (srcq[i].size() > 0 && (stall_drv[i] || hs[i])) void'(srcq[i].pop_front());
                stall_drv[i] = 1'b0;
                if (srcq[i].size() == 0) begin
                    s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0; s_tdata[DW*i +: DW] = '0;
                end else if (srcq[i][0][9]) begin
                    s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0; s_tdata[DW*i +: DW] = 8'hEE;
                    stall_drv[i] = 1'b1;
                end else begin
                    s_tvalid[i] = 1'b1;
                    s_tlast[i]  = srcq[i][0][8];
                    s_tdata[DW*i +: DW] = srcq[i][0][7:0];
                end
            end
            mac_tready_in = rdy_mode ? ~mac_tready_in : 1'b1;
            #4;
            hs = s_tvalid & s_tready;
            if (gap_pend) begin
                check("gap", {busy, mac_tvalid_out, mac_tlast_out, |s_tready}, 4'b1000);
                gap_pend = 1'b0;
            end
            check("tready_excl", 32'(s_tready & ~(3'b001 << grant_id)), 0);
            if (mac_tvalid_out && mac_tready_in) begin
                xcyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", 1, 0);
                end else begin
                    check("xfer", {grant_id, mac_tlast_out, mac_tdata_out}, exp_q.pop_front());
                    if (mac_tlast_out) gap_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        logic_rst_n = 1'b0;
        repeat (2) @(negedge logic_clk);
        #3;
        check("rst_busy",   busy, 0);
        check("rst_grant",  grant_id, 0);
        check("rst_tready", s_tready, 0);
        check("rst_valid",  mac_tvalid_out, 0);
        check("rst_last",   mac_tlast_out, 0);
        check("rst_data",   mac_tdata_out, 0);
        @(negedge logic_clk);
        #2 logic_rst_n = 1'b1;
        #1;

        // All sources requesting with 2-byte frames.
        push_frame(0, 8'h00, 2, -1, 0);
        push_frame(0, 8'h10, 2, -1, 0);
        push_frame(0, 8'h20, 2, -1, 0);
        push_frame(1, 8'h40, 2, -1, 0);
        push_frame(2, 8'h80, 2, -1, 0);
`ifdef MAC_TX_ARB_STRICT_PRIO_EN
        expect_frame(0, 8'h00, 2, 2);
        expect_frame(0, 8'h10, 2, 2);
        expect_frame(0, 8'h20, 2, 2);
        expect_frame(1, 8'h40, 2, 2);
        expect_frame(2, 8'h80, 2, 2);
`else
        expect_frame(0, 8'h00, 2, 2);
        expect_frame(1, 8'h40, 2, 2);
        expect_frame(2, 8'h80, 2, 2);
        expect_frame(0, 8'h10, 2, 2);
        expect_frame(0, 8'h20, 2, 2);
`endif
        wait_idle(200);

        // Single source, 5-byte frame, one-cycle grant latency.
        push_frame(1, 8'h11, 5, -1, 0);
        expect_frame(1, 8'h11, 5, 5);
        @(negedge logic_clk);
        #3;
        check("lat_idle_busy", busy, 0);
        @(negedge logic_clk);
        #3;
        check("lat_xfer", {busy, grant_id, mac_tvalid_out, mac_tdata_out}, {1'b1, 2'd1, 1'b1, 8'h11});
        wait_idle(200);

        // Backpressure: ready toggles every cycle.
        rdy_mode = 1'b1;
        push_frame(0, 8'hA0, 4, -1, 0);
        expect_frame(0, 8'hA0, 4, 4);
        wait_idle(200);
        rdy_mode = 1'b0;

        // Granted source stalls 10 cycles mid-frame while src0 requests.
        push_frame(2, 8'hC0, 4, 2, 10);
        expect_frame(2, 8'hC0, 4, 4);
        repeat (2) @(negedge logic_clk);
        #3;
        push_frame(0, 8'h30, 2, -1, 0);
        expect_frame(0, 8'h30, 2, 2);
        repeat (4) @(negedge logic_clk);
        #3;
        check("stall_hold", {busy, grant_id, mac_tvalid_out, s_tready[0]}, {1'b1, 2'd2, 1'b0, 1'b0});
        wait_idle(200);

        // Reset asserted during byte 3 of an 8-byte frame.
        push_frame(1, 8'h50, 8, -1, 0);
        expect_frame(1, 8'h50, 8, 2);
        repeat (4) @(negedge logic_clk);
        #2 logic_rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {busy, mac_tvalid_out, mac_tlast_out, mac_tdata_out, s_tready}, 0);
        check("mid_rst_grant", grant_id, 0);
        srcq[1].delete();
        @(negedge logic_clk);
        #2 logic_rst_n = 1'b1;
        #1;
        // rr_ptr back at 0: src0 must win over src2.
        push_frame(0, 8'h60, 2, -1, 0);
        push_frame(2, 8'h90, 2, -1, 0);
        expect_frame(0, 8'h60, 2, 2);
        expect_frame(2, 8'h90, 2, 2);
        wait_idle(200);

        // Back-to-back single-byte frames: XFER 1 + GAP 1 + IDLE 1 between bytes.
        xcyc_q.delete();
        push_frame(0, 8'h77, 1, -1, 0);
        push_frame(1, 8'h78, 1, -1, 0);
        expect_frame(0, 8'h77, 1, 1);
        expect_frame(1, 8'h78, 1, 1);
        wait_idle(200);
        check("single_cnt", xcyc_q.size(), 2);
        if (xcyc_q.size() == 2) check("single_spacing", xcyc_q[1] - xcyc_q[0], 3);

        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
